// File: rtl/memory_if.sv
// Shared payload types and the valid/ready stream interface for the memory stage.
//   memory_pkg : op_t, mm_t (execute -> memory beat), wb_t (memory -> writeback beat)
//   axis       : tvalid/tready/tdata stream; master drives tvalid+tdata, slave drives tready
package memory_pkg;
  typedef enum logic [2:0] {
    OP_NOP,
    OP_ALU,
    OP_LOAD,
    OP_STORE,
    OP_BRANCH,
    OP_JUMP
  } op_t;

  typedef struct packed {
    op_t        op;
    logic [2:0] br;     // funct3: access width for LOAD/STORE
  } mm_ctrl_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] alu;   // effective address or ALU result
    logic [31:0] rs2;   // store data
  } mm_data_t;

  typedef struct packed {
    mm_ctrl_t ctrl;
    mm_data_t data;
  } mm_t;

  typedef struct packed {
    op_t op;
  } wb_ctrl_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] rd_data;
  } wb_data_t;

  typedef struct packed {
    wb_ctrl_t ctrl;
    wb_data_t data;
  } wb_t;
endpackage

interface axis #(
  parameter int unsigned WIDTH = 32
);
  logic             tvalid;
  logic             tready;
  logic [WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/memory.sv
// Memory pipeline stage.
// Accepts mm_t beats from execute, performs data-memory loads/stores over a
// req/ack bus (byte-lane alignment, store strobes, load sign/zero extension)
// and emits a registered wb_t beat to writeback. Non-memory beats pass through.
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   source (slave)     mm_t beats from execute
//   sink (master)      wb_t beats to writeback
//   bypass             current sink rd_data for forwarding
//   fault              one-cycle pulse: misaligned, illegal width or timed-out access
//   dmem_*             data memory request bus; dmem_ack/dmem_rdata from memory
module memory
  import memory_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        aclk,
  input  logic        aresetn,
  axis.slave          source,
  axis.master         sink,
  output logic [31:0] bypass,
  output logic        fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state;
  logic [CW-1:0] tcnt;
  wb_t           out_beat;
  logic          out_valid;
  mm_t           in_beat;
  logic          ready;
  logic          accept;

  // Context of the in-flight access, needed to shape the load result.
  op_t           acc_op;
  logic [2:0]    acc_f3;
  logic [4:0]    acc_rd;
  logic [1:0]    acc_lane;

  // Decode of the incoming beat
  logic          is_load;
  logic          is_store;
  logic          width_ok;
  logic          misaligned;
  logic [3:0]    st_strb;
  logic [31:0]   st_data;
  logic [31:0]   ld_data;

  assign in_beat       = source.tdata;
  assign ready         = (state == S_IDLE) && (!out_valid || sink.tready);
  assign source.tready = ready;
  assign accept        = source.tvalid && ready;
  assign sink.tvalid   = out_valid;
  assign sink.tdata    = out_beat;
  assign bypass        = out_beat.data.rd_data;

  always_comb begin
    is_load    = (in_beat.ctrl.op == OP_LOAD);
    is_store   = (in_beat.ctrl.op == OP_STORE);
    width_ok   = 1'b0;
    misaligned = 1'b0;
    st_strb    = 4'b1111;
    st_data    = in_beat.data.rs2;
    if (is_load) begin
      width_ok = in_beat.ctrl.br inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else if (is_store) begin
      width_ok = in_beat.ctrl.br inside {3'b000, 3'b001, 3'b010};
    end
    case (in_beat.ctrl.br[1:0])
      2'b00: begin
        st_strb = 4'b0001 << in_beat.data.alu[1:0];
        st_data = {4{in_beat.data.rs2[7:0]}};
      end
      2'b01: begin
        misaligned = in_beat.data.alu[0];
        st_strb    = 4'b0011 << {in_beat.data.alu[1], 1'b0};
        st_data    = {2{in_beat.data.rs2[15:0]}};
      end
      2'b10: begin
        misaligned = (in_beat.data.alu[1:0] != 2'b00);
      end
      default: begin
        misaligned = 1'b0;
      end
    endcase
  end

  // Load extraction from the returned word; funct3[2] selects zero extension.
  always_comb begin
    logic [7:0]  lb;
    logic [15:0] lh;
    lb = 8'(dmem_rdata >> {acc_lane, 3'b000});
    lh = 16'(dmem_rdata >> {acc_lane[1], 4'b0000});
    case (acc_f3)
      3'b000:  ld_data = {{24{lb[7]}}, lb};
      3'b100:  ld_data = {24'h0, lb};
      3'b001:  ld_data = {{16{lh[15]}}, lh};
      3'b101:  ld_data = {16'h0, lh};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      tcnt       <= '0;
      out_valid  <= 1'b0;
      out_beat   <= '0;
      fault      <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wstrb <= '0;
      dmem_wdata <= '0;
      acc_op     <= OP_NOP;
      acc_f3     <= '0;
      acc_rd     <= '0;
      acc_lane   <= '0;
    end else begin
      fault <= 1'b0;
      // Drain first; a load below in the same cycle overrides this.
      if (sink.tready) begin
        out_valid <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!(is_load || is_store)) begin
              out_valid             <= 1'b1;
              out_beat.ctrl.op      <= in_beat.ctrl.op;
              out_beat.data.rd      <= in_beat.data.rd;
              out_beat.data.rd_data <= in_beat.data.alu;
            end else if (!width_ok || misaligned) begin
              fault                 <= 1'b1;
              out_valid             <= 1'b1;
              out_beat.ctrl.op      <= in_beat.ctrl.op;
              out_beat.data.rd      <= '0;
              out_beat.data.rd_data <= '0;
            end else begin
              state      <= S_ACCESS;
              tcnt       <= '0;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= {in_beat.data.alu[31:2], 2'b00};
              dmem_wstrb <= is_store ? st_strb : 4'b0000;
              dmem_wdata <= st_data;
              acc_op     <= in_beat.ctrl.op;
              acc_f3     <= in_beat.ctrl.br;
              acc_rd     <= in_beat.data.rd;
              acc_lane   <= in_beat.data.alu[1:0];
            end
          end
        end
        S_ACCESS: begin
          // Ack is checked before the limit so a same-cycle ack completes normally.
          if (dmem_ack) begin
            state                 <= S_IDLE;
            dmem_req              <= 1'b0;
            dmem_we               <= 1'b0;
            dmem_wstrb            <= '0;
            out_valid             <= 1'b1;
            out_beat.ctrl.op      <= acc_op;
            out_beat.data.rd      <= (acc_op == OP_STORE) ? 5'd0 : acc_rd;
            out_beat.data.rd_data <= (acc_op == OP_STORE) ? 32'd0 : ld_data;
          end else if ((TIMEOUT != 0) && (tcnt == CW'(TIMEOUT - 1))) begin
            state                 <= S_IDLE;
            dmem_req              <= 1'b0;
            dmem_we               <= 1'b0;
            dmem_wstrb            <= '0;
            fault                 <= 1'b1;
            out_valid             <= 1'b1;
            out_beat.ctrl.op      <= acc_op;
            out_beat.data.rd      <= '0;
            out_beat.data.rd_data <= '0;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for the memory stage: directed cases plus randomized
// beats checked against a byte-addressed reference memory.
module tb_memory;
  import memory_pkg::*;

  localparam int TO = 4;

  logic        aclk;
  logic        aresetn;
  logic [31:0] bypass;
  logic        fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  axis #(.WIDTH($bits(mm_t))) source_if ();
  axis #(.WIDTH($bits(wb_t))) sink_if ();

  memory #(.TIMEOUT(TO)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .source     (source_if),
    .sink       (sink_if),
    .bypass     (bypass),
    .fault      (fault),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wstrb (dmem_wstrb),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Byte-addressed reference memory (address wraps at 256 bytes).
  logic [7:0] mem [256];

  always_comb begin
    dmem_rdata = {mem[{dmem_addr[7:2], 2'b11}], mem[{dmem_addr[7:2], 2'b10}],
                  mem[{dmem_addr[7:2], 2'b01}], mem[{dmem_addr[7:2], 2'b00}]};
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input int f3);
    if (f3 % 4 == 0) return 1;
    if (f3 % 4 == 1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] alu, input int f3);
    logic [31:0] v;
    int sz;
    sz = size_of(f3);
    v  = 0;
    for (int k = 0; k < sz; k++) v = v | (32'(mem[(alu + k) & 255]) << (8 * k));
    if (f3 < 4 && sz < 4 && v[8 * sz - 1]) v = v | ~((32'd1 << (8 * sz)) - 1);
    return v;
  endfunction

  task automatic check_sink(input string tag, input op_t op, input logic [4:0] rd,
                            input logic [31:0] data);
    wb_t w;
    w = sink_if.tdata;
    check({tag, "_valid"}, 32'(sink_if.tvalid), 1);
    check({tag, "_op"}, 32'(w.ctrl.op), 32'(op));
    check({tag, "_rd"}, 32'(w.data.rd), 32'(rd));
    check({tag, "_data"}, w.data.rd_data, data);
    check({tag, "_bypass"}, bypass, data);
  endtask

  // Present a beat and return #1 after the edge on which it was accepted.
  task automatic push(input mm_t b);
    int n;
    @(negedge aclk);
    source_if.tvalid = 1'b1;
    source_if.tdata  = b;
    n = 0;
    while (!source_if.tready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check("accept_wait", 32'(n < 50), 1);
    @(posedge aclk);
    #1;
    source_if.tvalid = 1'b0;
  endtask

  // One complete transaction; delay = index of the request cycle carrying ack.
  task automatic run_op(input op_t op, input int f3, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] rs2, input int delay);
    mm_t         b;
    int          sz;
    int          reqcnt;
    bit          is_mem, legal, st, to;
    logic [31:0] ld, ewd;
    logic [3:0]  estrb;
    b.ctrl.op  = op;
    b.ctrl.br  = 3'(f3);
    b.data.rd  = rd;
    b.data.alu = alu;
    b.data.rs2 = rs2;
    st     = (op == OP_STORE);
    is_mem = (op == OP_LOAD) || st;
    sz     = size_of(f3);
    legal  = st ? (f3 inside {0, 1, 2}) : (f3 inside {0, 1, 2, 4, 5});
    legal  = legal && (alu % sz == 0);
    ld     = ref_load(alu, f3);
    estrb  = 4'(((1 << sz) - 1) << (alu % 4));
    ewd    = (sz == 1) ? 32'(rs2[7:0]) * 32'h0101_0101 :
             (sz == 2) ? 32'(rs2[15:0]) * 32'h0001_0001 : rs2;
    push(b);
    if (!is_mem) begin
      check("pass_req", 32'(dmem_req), 0);
      check("pass_fault", 32'(fault), 0);
      check_sink("pass", op, rd, alu);
    end else if (!legal) begin
      check("bad_req", 32'(dmem_req), 0);
      check("bad_fault", 32'(fault), 1);
      check_sink("bad", op, 5'd0, 32'd0);
    end else begin
      check("acc_req", 32'(dmem_req), 1);
      check("acc_we", 32'(dmem_we), 32'(st));
      check("acc_strb", 32'(dmem_wstrb), st ? 32'(estrb) : 0);
      if (st) check("acc_wdata", dmem_wdata, ewd);
      check("acc_sink_idle", 32'(sink_if.tvalid), 0);
      reqcnt = 0;
      for (int i = 0; i < TO + 4; i++) begin
        if (!dmem_req) break;
        reqcnt++;
        check("acc_addr", dmem_addr, alu & ~32'd3);
        dmem_ack = (i == delay);
        @(posedge aclk);
        #1;
        dmem_ack = 1'b0;
      end
      to = (delay >= TO);
      check("req_cycles", 32'(reqcnt), to ? TO : delay + 1);
      check("done_fault", 32'(fault), 32'(to));
      if (to || st) check_sink("done", op, 5'd0, 32'd0);
      else          check_sink("done", op, rd, ld);
      if (st && !to)
        for (int k = 0; k < sz; k++) mem[(alu + k) & 255] = 8'(rs2 >> (8 * k));
    end
    @(posedge aclk);
    #1;
    check("after_fault", 32'(fault), 0);
    check("after_valid", 32'(sink_if.tvalid), 0);
  endtask

  initial begin
    mm_t b;
    wb_t w;
    aresetn          = 1'b0;
    dmem_ack         = 1'b0;
    source_if.tvalid = 1'b0;
    source_if.tdata  = '0;
    sink_if.tready   = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    #22;
    check("rst_valid", 32'(sink_if.tvalid), 0);
    check("rst_req", 32'(dmem_req), 0);
    check("rst_we", 32'(dmem_we), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_strb", 32'(dmem_wstrb), 0);
    check("rst_ready", 32'(source_if.tready), 1);
    @(negedge aclk);
    aresetn = 1'b1;

    // Directed cases
    run_op(OP_ALU, 0, 5'd5, 32'h0000_1234, 32'h0, 0);
    mem[0] = 8'h01; mem[1] = 8'h7F; mem[2] = 8'hFF; mem[3] = 8'h80;
    run_op(OP_LOAD, 0, 5'd7, 32'h0000_0103, 32'h0, 0);
    run_op(OP_LOAD, 4, 5'd7, 32'h0000_0103, 32'h0, 0);
    check("lb_ref", ref_load(32'h103, 0), 32'hFFFF_FF80);
    run_op(OP_STORE, 1, 5'd9, 32'h0000_0202, 32'hAAAA_BEEF, 2);
    run_op(OP_LOAD, 2, 5'd1, 32'h0000_0101, 32'h0, 0);
    run_op(OP_LOAD, 3, 5'd1, 32'h0000_0100, 32'h0, 0);
    run_op(OP_LOAD, 2, 5'd3, 32'h0000_0040, 32'h0, 20);
    run_op(OP_LOAD, 1, 5'd3, 32'h0000_0042, 32'h0, TO - 1);

    // Stray ack while idle does nothing
    @(negedge aclk);
    dmem_ack = 1'b1;
    @(posedge aclk);
    #1;
    dmem_ack = 1'b0;
    check("stray_valid", 32'(sink_if.tvalid), 0);
    check("stray_fault", 32'(fault), 0);

    // Backpressure, then simultaneous drain and load
    sink_if.tready = 1'b0;
    b = '0;
    b.ctrl.op = OP_ALU; b.data.rd = 5'd11; b.data.alu = 32'hCAFE_0001;
    push(b);
    b.data.rd = 5'd12; b.data.alu = 32'hCAFE_0002;
    @(negedge aclk);
    source_if.tvalid = 1'b1;
    source_if.tdata  = b;
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", 32'(source_if.tready), 0);
      check_sink("bp_hold", OP_ALU, 5'd11, 32'hCAFE_0001);
      @(negedge aclk);
    end
    sink_if.tready = 1'b1;
    #1;
    check("bp_release_ready", 32'(source_if.tready), 1);
    @(posedge aclk);
    #1;
    source_if.tvalid = 1'b0;
    check_sink("bp_swap", OP_ALU, 5'd12, 32'hCAFE_0002);
    @(posedge aclk);
    #1;
    check("bp_drained", 32'(sink_if.tvalid), 0);

    // Reset in the middle of an access
    b = '0;
    b.ctrl.op = OP_LOAD; b.ctrl.br = 3'b010; b.data.rd = 5'd4; b.data.alu = 32'h80;
    push(b);
    check("mid_req", 32'(dmem_req), 1);
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    check("mid_rst_req", 32'(dmem_req), 0);
    check("mid_rst_valid", 32'(sink_if.tvalid), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk);
      #1;
      check("post_rst_valid", 32'(sink_if.tvalid), 0);
      check("post_rst_req", 32'(dmem_req), 0);
    end

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      op_t op;
      int  pick;
      pick = $urandom_range(0, 5);
      op = (pick == 0) ? OP_ALU : (pick == 1) ? OP_BRANCH : (pick == 2) ? OP_NOP :
           (pick == 3) ? OP_STORE : OP_LOAD;
      run_op(op, $urandom_range(0, 7), 5'($urandom), $urandom & 32'h0000_03FF,
             $urandom, $urandom_range(0, 6));
    end

    w = sink_if.tdata;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- Memory stage, directly downstream of the execute stage; consumes the registered mm_t beat that execute produces.
- Performs data-memory loads and stores over a simple req/ack bus: byte-lane alignment, store strobes, load extraction with sign/zero extension.
- Non-memory beats pass through untouched.
- Produces a registered wb_t beat for writeback, plus a forwarding tap.

Parameters:
TIMEOUT, 255, max cycles in ACCESS awaiting dmem_ack; 0 disables the timeout.

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
source  axis.slave  mm_t  from execute: ctrl.op, ctrl.br (funct3), data.rd, data.alu (address/result), data.rs2 (store data)
sink  axis.master  wb_t  to writeback: ctrl.op, data.rd, data.rd_data
bypass  output  32  current sink rd_data, for forwarding
fault  output  1  one-cycle pulse on misaligned, illegal-width or timed-out access
dmem_req  output  1  access request, held until ack
dmem_we  output  1  1 = store
dmem_addr  output  32  {alu[31:2], 2'b00}
dmem_wstrb  output  4  store byte enables
dmem_wdata  output  32  lane-replicated store data
dmem_ack  input  1  access complete; sampled only while dmem_req = 1
dmem_rdata  input  32  load word, valid with dmem_ack

Behaviour:
- Reset: aclk single clock; aresetn asynchronous, active-low.
  - state = IDLE.
  - sink.tvalid, dmem_req, dmem_we, fault = 0; dmem_wstrb = 0.
  - Reset mid-ACCESS abandons the access; no sink beat is produced.
- States: IDLE, ACCESS.
- Acceptance: source.tready = (state == IDLE) & (~sink.tvalid | sink.tready). A beat is accepted when source.tvalid & source.tready.
- Non-LOAD/STORE accepted:
  - Next cycle: sink.tvalid = 1; rd_data = alu; rd, op copied. Latency 1.
- Width decode (funct3):
  - Loads: LB = 000, LH = 001, LW = 010, LBU = 100, LHU = 101.
  - Stores: SB = 000, SH = 001, SW = 010.
  - Any other code is illegal.
- Misaligned: halfword with alu[0] = 1; word with alu[1:0] != 0.
- Illegal or misaligned LOAD/STORE accepted:
  - No request issued.
  - Next cycle: fault = 1 for one cycle; sink beat with rd = 0, rd_data = 0.
- Legal LOAD/STORE accepted:
  - Next cycle: state = ACCESS; dmem_req = 1; dmem_we, dmem_addr, dmem_wstrb, dmem_wdata registered and held stable until ack.
  - SB: wstrb = 4'b0001 << alu[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 4'b0011 << {alu[1], 1'b0}; wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 4'b1111; wdata = rs2.
  - Loads: wstrb = 0.
- ACCESS with dmem_ack = 1:
  - Next cycle: dmem_req = 0; state = IDLE; sink.tvalid = 1.
  - LB/LBU: byte at dmem_rdata[8*alu[1:0] +: 8], sign- or zero-extended.
  - LH/LHU: half at dmem_rdata[16*alu[1] +: 16], sign- or zero-extended.
  - LW: full word.
  - Store: rd forced to 0, rd_data = 0.
  - Minimum load-use latency: 2 cycles from acceptance (ack in first ACCESS cycle).
- Timeout (TIMEOUT != 0):
  - Counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT: dmem_req drops, fault pulses, sink beat with rd = 0, state = IDLE.
  - Ack on the same cycle as the limit wins (normal completion).
- Sink:
  - Register is empty whenever ACCESS completes, because acceptance required the sink free or draining.
  - sink.tvalid clears on sink.tready when no new beat is loaded.
  - A simultaneous drain + load keeps tvalid = 1 with the new data.
- dmem_ack while dmem_req = 0: ignored.
- bypass = sink.tdata.data.rd_data, combinational from the register.

Test Plan:
- Non-memory beat, ALU op, alu = 0x0000_1234, rd = 5, sink.tready = 1 -> sink.tvalid next cycle, rd_data = 0x0000_1234, rd = 5, no dmem_req.
- LB, alu = 0x103, dmem_rdata = 0x80FF_7F01, ack in first ACCESS cycle -> dmem_addr = 0x100, rd_data = 0xFFFF_FF80; same with LBU -> 0x0000_0080; total latency 2.
- SH, alu = 0x202, rs2 = 0xAAAA_BEEF, ack after 3 cycles -> wstrb = 4'b1100, wdata = 0xBEEF_BEEF, dmem_req held 3 cycles, sink beat rd = 0.
- LW, alu = 0x101 -> fault pulse, no dmem_req, sink beat rd = 0; funct3 = 3'b011 load -> same.
- TIMEOUT = 4, no ack -> dmem_req high exactly 4 cycles, fault pulse, state back to IDLE, next source beat accepted.
- aresetn low during ACCESS -> dmem_req and sink.tvalid drop immediately (async); no beat after release; sink.tready = 0 backpressure holds source.tready = 0.
